// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the pulse generator and its sweep control logic.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic [3:0] FREQ_MIN = 4'd1;
    localparam logic [3:0] FREQ_MAX = 4'd10;
    localparam logic [3:0] FREQ_RST = 4'd5;

    localparam logic [1:0] DUTY_HALF    = 2'b00;
    localparam logic [1:0] DUTY_THIRD   = 2'b01;
    localparam logic [1:0] DUTY_QUARTER = 2'b10;
    localparam logic [1:0] DUTY_SEVENTH = 2'b11;

    // True when f is a frequency the generator can produce.
    function automatic logic freq_ok(input logic [3:0] f);
        return (f >= FREQ_MIN) && (f <= FREQ_MAX);
    endfunction

endpackage

// File: rtl/pulse_sweep_controller_if.sv
// Control/config/generator-drive bundle of the sweep controller.
interface pulse_sweep_controller_if;
    logic       start;
    logic       stop;
    logic [3:0] cfg_f_start;
    logic [3:0] cfg_f_stop;
    logic [1:0] cfg_duty;
    logic       cfg_duty_all;
    logic       cfg_loop;
    logic [3:0] gen_freq_mhz;
    logic [1:0] gen_duty_mode;
    logic       gen_enable;
    logic       busy;
    logic       done;
    logic       err;
    logic       aborted;

    // Front-panel / UART side.
    modport master (
        output start, stop, cfg_f_start, cfg_f_stop, cfg_duty, cfg_duty_all, cfg_loop,
        input  gen_freq_mhz, gen_duty_mode, gen_enable, busy, done, err, aborted
    );

    // Sweep controller side.
    modport slave (
        input  start, stop, cfg_f_start, cfg_f_stop, cfg_duty, cfg_duty_all, cfg_loop,
        output gen_freq_mhz, gen_duty_mode, gen_enable, busy, done, err, aborted
    );
endinterface

// File: rtl/sweep_step_timer.sv
// Dwell/gap step timer: counts up while enabled, tc on the terminal value.
// Clearing whenever disabled or at tc means every entry into RUN/GAP starts at 0.
module sweep_step_timer #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] last,
    output logic             tc
);
    logic [CNT_W-1:0] cnt;

    assign tc = en && (cnt == last);

    // Count cycles of the current step; restart on terminal count or when idle.
    always_ff @(posedge clk) begin
        if (!rst_n)          cnt <= '0;
        else if (!en || tc)  cnt <= '0;
        else                 cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: rtl/pulse_sweep_controller.sv
// Sequences the pulse generator through a frequency (and optional duty) sweep,
// holding each setting for a dwell and disabling it for a gap between settings.
module pulse_sweep_controller
    import pulse_gen_pkg::*;
#(
    parameter int DWELL_CYCLES = 1_000_000,
    parameter int GAP_CYCLES   = 4,
    parameter int CNT_W        = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pulse_sweep_controller_if.slave  bus
);
    state_t     state;

    // Configuration captured at start
    logic [3:0] f_start_q, f_stop_q;
    logic [1:0] duty_cfg_q;
    logic       duty_all_q, loop_q, dir_up_q;

    // Registered outputs
    logic [3:0] freq;
    logic [1:0] duty;
    logic       enable, busy, done, err, aborted;

    logic             tmr_en, tc;
    logic [CNT_W-1:0] tmr_last;

    assign tmr_en   = (state == S_RUN) || (state == S_GAP);
    assign tmr_last = (state == S_GAP) ? CNT_W'(GAP_CYCLES - 1) : CNT_W'(DWELL_CYCLES - 1);

    sweep_step_timer #(.CNT_W(CNT_W)) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (tmr_en),
        .last (tmr_last),
        .tc   (tc)
    );

    // Sweep FSM with config latch, step arithmetic and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            f_start_q  <= FREQ_RST;
            f_stop_q   <= FREQ_RST;
            duty_cfg_q <= DUTY_HALF;
            duty_all_q <= 1'b0;
            loop_q     <= 1'b0;
            dir_up_q   <= 1'b0;
            freq       <= FREQ_RST;
            duty       <= DUTY_HALF;
            enable     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        f_start_q  <= bus.cfg_f_start;
                        f_stop_q   <= bus.cfg_f_stop;
                        duty_cfg_q <= bus.cfg_duty;
                        duty_all_q <= bus.cfg_duty_all;
                        loop_q     <= bus.cfg_loop;
                        dir_up_q   <= (bus.cfg_f_start <= bus.cfg_f_stop);
                        busy       <= 1'b1;
                        aborted    <= 1'b0;
                        if (freq_ok(bus.cfg_f_start) && freq_ok(bus.cfg_f_stop)) begin
                            err    <= 1'b0;
                            freq   <= bus.cfg_f_start;
                            duty   <= bus.cfg_duty_all ? DUTY_HALF : bus.cfg_duty;
                            enable <= 1'b1;
                            state  <= S_RUN;
                        end else begin
                            err    <= 1'b1;
                            done   <= 1'b1;
                            state  <= S_FIN;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.stop) begin
                        enable  <= 1'b0;
                        aborted <= 1'b1;
                        done    <= 1'b1;
                        state   <= S_FIN;
                    end else if (tc) begin
                        enable <= 1'b0;
                        state  <= S_GAP;
                        if (duty_all_q && duty != DUTY_SEVENTH) begin
                            duty <= duty + 2'd1;
                        end else if (freq != f_stop_q) begin
                            freq <= dir_up_q ? freq + 4'd1 : freq - 4'd1;
                            if (duty_all_q) duty <= DUTY_HALF;
                        end else if (loop_q) begin
                            freq <= f_start_q;
                            duty <= duty_all_q ? DUTY_HALF : duty_cfg_q;
                        end else begin
                            done  <= 1'b1;
                            state <= S_FIN;
                        end
                    end
                end
                S_GAP: begin
                    if (bus.stop) begin
                        aborted <= 1'b1;
                        done    <= 1'b1;
                        state   <= S_FIN;
                    end else if (tc) begin
                        enable <= 1'b1;
                        state  <= S_RUN;
                    end
                end
                S_FIN: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.gen_freq_mhz  = freq;
    assign bus.gen_duty_mode = duty;
    assign bus.gen_enable    = enable;
    assign bus.busy          = busy;
    assign bus.done          = done;
    assign bus.err           = err;
    assign bus.aborted       = aborted;
endmodule

// File: tb/tb_pulse_sweep_controller.sv
// Directed + randomized checks of the sweep controller against a step-list model.
module tb_pulse_sweep_controller;
    localparam int D = 8;
    localparam int G = 2;

    typedef struct {
        int f;
        int d;
    } step_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    step_t steps[$];

    always #5 clk = ~clk;

    pulse_sweep_controller_if bus ();

    pulse_sweep_controller #(.DWELL_CYCLES(D), .GAP_CYCLES(G), .CNT_W(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int f, input int d, input int en,
                           input int bsy, input int dn, input int er, input int ab);
        chk({tag, ".freq"},    32'(bus.gen_freq_mhz),  32'(f));
        chk({tag, ".duty"},    32'(bus.gen_duty_mode), 32'(d));
        chk({tag, ".enable"},  32'(bus.gen_enable),    32'(en));
        chk({tag, ".busy"},    32'(bus.busy),          32'(bsy));
        chk({tag, ".done"},    32'(bus.done),          32'(dn));
        chk({tag, ".err"},     32'(bus.err),           32'(er));
        chk({tag, ".aborted"}, 32'(bus.aborted),       32'(ab));
    endtask

    // Expected ordered list of (freq,duty) settings for one pass of a sweep.
    task automatic build(input int fs, input int fe, input int dall, input int d);
        int f;
        steps.delete();
        f = fs;
        forever begin
            if (dall != 0) for (int k = 0; k < 4; k++) steps.push_back('{f, k});
            else steps.push_back('{f, d});
            if (f == fe) break;
            f = (fs <= fe) ? f + 1 : f - 1;
        end
    endtask

    task automatic set_cfg(input int fs, input int fe, input int dall, input int d, input int lp);
        bus.cfg_f_start  = 4'(fs);
        bus.cfg_f_stop   = 4'(fe);
        bus.cfg_duty_all = 1'(dall);
        bus.cfg_duty     = 2'(d);
        bus.cfg_loop     = 1'(lp);
    endtask

    task automatic scramble_cfg();
        set_cfg($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1),
                $urandom_range(0, 3), $urandom_range(0, 1));
    endtask

    // One non-looping sweep; optional stop at (stop_step, stop_cyc) of a dwell.
    task automatic run_sweep(input string tag, input int fs, input int fe, input int dall,
                             input int d, input int stop_step, input int stop_cyc);
        int n;
        build(fs, fe, dall, d);
        n = steps.size();
        set_cfg(fs, fe, dall, d, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        scramble_cfg();
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < D; c++) begin
                chk_out(tag, steps[i].f, steps[i].d, 1, 1, 0, 0, 0);
                bus.start = (i == 0 && c == 1);
                if (i == stop_step && c == stop_cyc) begin
                    bus.stop = 1'b1;
                    tick();
                    bus.stop = 1'b0;
                    chk_out({tag, ".stopfin"}, steps[i].f, steps[i].d, 0, 1, 1, 0, 1);
                    tick();
                    chk_out({tag, ".stopidle"}, steps[i].f, steps[i].d, 0, 0, 0, 0, 1);
                    return;
                end
                tick();
            end
            if (i != n - 1) begin
                for (int c = 0; c < G; c++) begin
                    chk_out({tag, ".gap"}, steps[i+1].f, steps[i+1].d, 0, 1, 0, 0, 0);
                    tick();
                end
            end
        end
        chk_out({tag, ".fin"}, steps[n-1].f, steps[n-1].d, 0, 1, 1, 0, 0);
        tick();
        chk_out({tag, ".idle"}, steps[n-1].f, steps[n-1].d, 0, 0, 0, 0, 0);
    endtask

    task automatic run_invalid(input string tag, input int fs, input int fe,
                               input int pf, input int pd);
        set_cfg(fs, fe, $urandom_range(0, 1), $urandom_range(0, 3), 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk_out({tag, ".fin"}, pf, pd, 0, 1, 1, 1, 0);
        tick();
        for (int c = 0; c < 3; c++) begin
            chk_out({tag, ".idle"}, pf, pd, 0, 0, 0, 1, 0);
            tick();
        end
    endtask

    initial begin
        int fs, fe, dall, d;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        set_cfg(3, 5, 0, 1, 0);
        tick();
        tick();
        chk_out("reset", 5, 0, 0, 0, 0, 0, 0);
        bus.stop = 1'b1;
        rst_n = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk_out("idle_stop", 5, 0, 0, 0, 0, 0, 0);

        run_sweep("up", 3, 5, 0, 1, -1, 0);
        run_sweep("down_all", 2, 1, 1, 0, -1, 0);
        run_sweep("single", 10, 10, 0, 3, -1, 0);
        run_sweep("stop_tc", 6, 9, 0, 2, 1, D - 1);
        run_sweep("stop_gap_prev", 1, 10, 1, 0, 5, 4);

        // Loop at a single frequency, stopped during the third dwell.
        set_cfg(4, 4, 0, 2, 1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        scramble_cfg();
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < D; c++) begin
                chk_out("loop.run", 4, 2, 1, 1, 0, 0, 0);
                if (p == 2 && c == 3) bus.stop = 1'b1;
                tick();
                if (bus.stop) break;
            end
            if (bus.stop) break;
            for (int c = 0; c < G; c++) begin
                chk_out("loop.gap", 4, 2, 0, 1, 0, 0, 0);
                tick();
            end
        end
        bus.stop = 1'b0;
        chk_out("loop.fin", 4, 2, 0, 1, 1, 0, 1);
        tick();
        chk_out("loop.idle", 4, 2, 0, 0, 0, 0, 1);

        run_invalid("inv_fs0", 0, 5, 4, 2);
        run_invalid("inv_fe11", 3, 11, 4, 2);
        run_invalid("inv_rand", $urandom_range(11, 15), $urandom_range(1, 10), 4, 2);

        // Randomized sweeps, each started in the cycle after the previous FIN.
        for (int r = 0; r < 8; r++) begin
            fs   = $urandom_range(1, 10);
            fe   = $urandom_range(1, 10);
            dall = $urandom_range(0, 1);
            d    = $urandom_range(0, 3);
            run_sweep("rand", fs, fe, dall, d, -1, 0);
        end

        // Reset during the first gap of a 7->9 sweep.
        set_cfg(7, 9, 0, 1, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (D) tick();
        chk_out("rst.gap", 8, 1, 0, 1, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        chk_out("rst.mid", 5, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        chk_out("rst.after", 5, 0, 0, 0, 0, 0, 0);

        run_sweep("post_rst", 9, 7, 0, 3, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
